// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the receptive-field stream scheduler.
package rf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_STREAM
  } state_t;

  localparam int ROW_W = 6;

  function automatic int calc_p(input int w, input int f);
    return (w - f + 1) / 2;
  endfunction

  function automatic int calc_k(input int d, input int f);
    return d * f * f;
  endfunction

  function automatic int calc_r(input int h, input int f);
    return h - f + 1;
  endfunction

  // Tap order inside one window: depth, then filter row, then filter column.
  function automatic int beat_index(input int k, input int i, input int j, input int f);
    return (k * f + i) * f + j;
  endfunction

endpackage

// File: rtl/rf_lane_mux.sv
// Picks one word per PE lane from the captured bundle for the current beat.
// Bundle word 0 and lane 0 both sit in the most significant position.
module rf_lane_mux
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int P          = 1,
  parameter int K          = 1,
  parameter int BW         = 1
) (
  input  logic [P*K*DATA_WIDTH-1:0] i_bundle,
  input  logic [BW-1:0]             i_beat,
  output logic [P*DATA_WIDTH-1:0]   o_data
);

  logic [DATA_WIDTH-1:0] w_words [P][K];

  genvar gi, gj;
  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      for (gj = 0; gj < K; gj++) begin : g_tap
        assign w_words[gi][gj] = i_bundle[(P*K-1-(gi*K+gj))*DATA_WIDTH +: DATA_WIDTH];
      end
      assign o_data[(P-1-gi)*DATA_WIDTH +: DATA_WIDTH] = w_words[gi][i_beat];
    end
  endgenerate

endmodule

// File: rtl/rf_stream_scheduler.sv
// Steps the selector over every row/half, captures each bundle and streams it one tap per beat.
// Optional stall counter: define RF_SCHED_STALL_CNT_EN.
module rf_stream_scheduler
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  output logic                                               busy,
  output logic                                               done,
  output logic [ROW_W-1:0]                                   row_number,
  output logic [5:0]                                         column,
  input  logic [calc_p(W,F)*calc_k(D,F)*DATA_WIDTH-1:0]      rf_in,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [calc_p(W,F)*DATA_WIDTH-1:0]                  out_data,
  output logic                                               out_first,
  output logic                                               out_last,
  output logic [31:0]                                        stall_cycles
);

  localparam int P  = calc_p(W, F);
  localparam int K  = calc_k(D, F);
  localparam int R  = calc_r(H, F);
  localparam int BW = (K > 1) ? $clog2(K) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(R - 1);
  localparam logic [BW-1:0]    BEAT_LAST = BW'(K - 1);

  generate
    if (R < 1 || R > 64 || P < 1) begin : g_geometry_check
      $error("rf_stream_scheduler: unsupported geometry (R must be 1..64, P at least 1)");
    end
  endgenerate

  state_t                  r_state;
  logic [ROW_W-1:0]        r_row;
  logic                    r_col;
  logic [BW-1:0]           r_beat;
  logic [P*K*DATA_WIDTH-1:0] r_bundle;
  logic                    r_busy;
  logic                    r_done;

  logic w_valid;
  logic w_last_beat;

  assign w_valid     = (r_state == ST_STREAM);
  assign w_last_beat = (r_beat == BEAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_col    <= 1'b0;
      r_beat   <= '0;
      r_bundle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SELECT;
            r_row   <= '0;
            r_col   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        // Selector output has had a full cycle to settle on the new row/half.
        ST_SELECT: begin
          r_bundle <= rf_in;
          r_beat   <= '0;
          r_state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (w_last_beat) begin
              if (!r_col) begin
                r_col   <= 1'b1;
                r_state <= ST_SELECT;
              end else if (r_row < ROW_LAST) begin
                r_row   <= r_row + 1'b1;
                r_col   <= 1'b0;
                r_state <= ST_SELECT;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rf_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .P          (P),
    .K          (K),
    .BW         (BW)
  ) u_lane_mux (
    .i_bundle (r_bundle),
    .i_beat   (r_beat),
    .o_data   (out_data)
  );

`ifdef RF_SCHED_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_stall <= '0;
    end else if (w_valid && !out_ready && r_stall != '1) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign row_number = r_row;
  assign column     = {5'b0, r_col};
  assign out_valid  = w_valid;
  assign out_first  = w_valid && (r_beat == '0);
  assign out_last   = w_valid && w_last_beat;

endmodule

// File: tb/tb_rf_stream_scheduler.sv
// Self-checking bench: behavioural selector plus a pass/beat scoreboard over full image sweeps.
module tb_rf_stream_scheduler;

  localparam int DW = 32;
  localparam int D  = 1;
  localparam int H  = 6;
  localparam int W  = 6;
  localparam int F  = 3;
  localparam int P  = (W - F + 1) / 2;
  localparam int K  = D * F * F;
  localparam int R  = H - F + 1;
  localparam int NW = P * K;
  localparam int PASSES = 2 * R;
  localparam int FULL_CYCLES = 1 + PASSES * (1 + K);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [5:0]        row_number;
  logic [5:0]        column;
  logic [NW*DW-1:0]  rf_in;
  logic              out_valid;
  logic              out_ready;
  logic [P*DW-1:0]   out_data;
  logic              out_first;
  logic              out_last;
  logic [31:0]       stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_stream_scheduler #(
    .DATA_WIDTH (DW),
    .D          (D),
    .H          (H),
    .W          (W),
    .F          (F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .row_number   (row_number),
    .column       (column),
    .rf_in        (rf_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_first    (out_first),
    .out_last     (out_last),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Receptive-field selector: image word at (y, x) is y*W + x, bundle word 0 most significant.
  always_comb begin
    rf_in = '0;
    for (int p = 0; p < P; p++)
      for (int c = 0; c < D; c++)
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            rf_in[(NW-1-(p*K+(c*F+i)*F+j))*DW +: DW] =
              DW'(c*H*W + (int'(row_number)+i)*W + int'(column)*P + p + j);
  end

  // Expected lanes for a pass position: lane p looks at pixel (row+i, col*P+p+j).
  function automatic logic [P*DW-1:0] model(input int row, input int col, input int beat);
    logic [P*DW-1:0] v;
    int c, i, j;
    v = '0;
    c = beat / (F*F);
    i = (beat / F) % F;
    j = beat % F;
    for (int p = 0; p < P; p++)
      v[(P-1-p)*DW +: DW] = DW'(c*H*W + (row+i)*W + col*P + p + j);
    return v;
  endfunction

  function automatic logic [63:0] pair(input int a, input int b);
    logic [31:0] ha;
    logic [31:0] hb;
    ha = a[31:0];
    hb = b[31:0];
    return {ha, hb};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // mode 0: ready held high, 1: random ready, 2: five-cycle hold on pass 0 beat 3
  task automatic run_image(input int mode, input bit poke_start, input int exp_cycles);
    int cyc, pass, beat, hold, stalls, first_cyc;
    bit sel;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1; pass = 0; beat = 0; hold = 0; stalls = 0; first_cyc = -1; sel = 1'b1;
    chk("select_row", 64'(row_number), 64'd0);
    chk("select_col", 64'(column), 64'd0);
    while (pass < PASSES && cyc < 3000) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && !sel && pass == 0 && beat == 3 && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else out_ready = 1'b1;
      start = (poke_start && cyc == 23) ? 1'b1 : 1'b0;
      chk("busy", 64'(busy), 64'd1);
      chk("no_early_done", 64'(done), 64'd0);
      if (sel) begin
        chk("select_gap_valid", 64'(out_valid), 64'd0);
        sel = 1'b0;
      end else begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("valid", 64'(out_valid), 64'd1);
        chk("row", 64'(row_number), 64'(pass / 2));
        chk("col", 64'(column), 64'(pass % 2));
        chk("data", 64'(out_data), 64'(model(pass / 2, pass % 2, beat)));
        chk("first", 64'(out_first), 64'(beat == 0));
        chk("last", 64'(out_last), 64'(beat == K-1));
        if (pass == 0 && beat == 0) chk("first_beat_lanes", 64'(out_data), pair(0, 1));
        if (pass == 0 && beat == 3) chk("beat3_lanes", 64'(out_data), pair(6, 7));
        if (pass == 0 && beat == 4) chk("beat4_lanes", 64'(out_data), pair(7, 8));
        if (pass == 0 && beat == 8) chk("beat8_lanes", 64'(out_data), pair(14, 15));
        if (pass == PASSES-1 && beat == 0) chk("last_pass_lanes", 64'(out_data), pair(20, 21));
        if (out_ready) begin
          beat++;
          if (beat == K) begin
            beat = 0;
            pass++;
            sel = 1'b1;
          end
        end else begin
          stalls++;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("sweep_complete", 64'(pass), 64'(PASSES));
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_row_held", 64'(row_number), 64'(R-1));
    chk("done_col_held", 64'(column), 64'd1);
    chk("first_valid_cycle", 64'(first_cyc), 64'd2);
    if (exp_cycles > 0) chk("done_cycle", 64'(cyc), 64'(exp_cycles));
`ifdef RF_SCHED_STALL_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(stalls));
`else
    chk("stall_cycles_tied", 64'(stall_cycles), 64'd0);
`endif
    $display("image mode=%0d passes=%0d done_cycle=%0d stalls=%0d", mode, pass, cyc, stalls);
  endtask

  initial begin
    int cnt;
    bit found;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_row", 64'(row_number), 64'd0);
    chk("rst_col", 64'(column), 64'd0);
    chk("rst_first", 64'(out_first), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    run_image(0, 1'b0, FULL_CYCLES);
    run_image(1, 1'b1, 0);
    step();
    step();
    chk("idle_after_random_busy", 64'(busy), 64'd0);
    chk("idle_after_random_valid", 64'(out_valid), 64'd0);
    run_image(2, 1'b0, FULL_CYCLES + 5);

    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (out_valid && row_number == 6'd2 && column == 6'd0) begin
        if (cnt == 5) found = 1'b1;
        else cnt++;
      end
      if (!found) step();
    end
    chk("reached_pass_2_0_beat5", 64'(found), 64'd1);
    chk("pre_reset_data", 64'(out_data), 64'(model(2, 0, 5)));
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_row", 64'(row_number), 64'd0);
    chk("midrst_col", 64'(column), 64'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("no_done_after_reset", 64'(done), 64'd0);
    end
    run_image(0, 1'b0, FULL_CYCLES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
